// File: rtl/id_inst_queue_if.sv
// Fetch/decode handshake bundle for id_inst_queue.
// The master side is fetch plus decode control; the slave side is the queue itself.
interface id_inst_queue_if #(
  parameter int WIDTH = 32,
  parameter int SLOTS = 2,
  parameter int DEPTH = 4
);
  logic                           in_valid;
  logic                           in_ready;
  logic [WIDTH-1:0]               in_inst;
  logic [SLOTS*WIDTH-1:0]         in_slots;
  logic                           stall;
  logic                           squash;
  logic                           out_valid;
  logic [WIDTH-1:0]               out_inst;
  logic [SLOTS*WIDTH-1:0]         out_slots;
  logic [$clog2(DEPTH+1)-1:0]     count;

  modport master (
    output in_valid, in_inst, in_slots, stall, squash,
    input  in_ready, out_valid, out_inst, out_slots, count
  );

  modport slave (
    input  in_valid, in_inst, in_slots, stall, squash,
    output in_ready, out_valid, out_inst, out_slots, count
  );
endinterface

// File: rtl/id_inst_queue.sv
// DEPTH-entry FIFO between fetch and decode. Each entry holds an instruction plus SLOTS payload words.
// Squash flushes every entry; an empty queue presents NOP to decode.
module id_inst_queue #(
  parameter int          WIDTH = 32,
  parameter int          SLOTS = 2,
  parameter int          DEPTH = 4,
  parameter logic [31:0] NOP   = 32'h00000015
) (
  input  logic            clk,
  input  logic            reset,
  id_inst_queue_if.slave  q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = WIDTH * (SLOTS + 1);
  localparam logic [WIDTH-1:0] NOP_W = WIDTH'(NOP);

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] cnt;
  logic [EW-1:0] head;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));
  assign push  = q.in_valid & ~full & ~q.squash;
  assign pop   = ~empty & ~q.stall & ~q.squash;
  assign head  = mem[rp];

  assign q.in_ready  = ~full;
  assign q.out_valid = ~empty;
  assign q.out_inst  = empty ? NOP_W : head[WIDTH-1:0];
  assign q.out_slots = empty ? '0 : head[EW-1:WIDTH];
  assign q.count     = cnt;

  // Pointers and occupancy; reset outranks squash, which outranks any push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (q.squash) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop)  rp <= rp + PW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // Storage is deliberately left uncleared by reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (!reset && push) mem[wp] <= {q.in_slots, q.in_inst};
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (reset) !(push && full));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (reset) !(pop && empty));
  a_count_bound:  assert property (@(posedge clk) disable iff (reset) cnt <= CW'(DEPTH));
endmodule

// File: doc/id_inst_queue.md
Name: id_inst_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register.
- Replaces the fixed inst/delay/delay2 latch with a DEPTH-entry FIFO between fetch and decode.
- Each entry carries one instruction word plus SLOTS trailing payload words (delay-slot PC, second delay word, ...).
- Provides valid/ready handshaking, stall-driven hold, and squash that flushes all entries and presents a NOP to decode.

Parameters:
WIDTH, 32, bits per instruction word and per payload slot
SLOTS, 2, number of payload words carried with each instruction (>=1)
DEPTH, 4, number of queue entries (power of two, >=2)
NOP, 32'h00000015, instruction presented to decode when the queue is empty, squashed or in reset

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous active-high reset
in_valid  in  1  fetch presents an entry
in_ready  out  1  queue can accept an entry this cycle
in_inst  in  WIDTH  fetched instruction
in_slots  in  SLOTS*WIDTH  payload words; slot k occupies bits [k*WIDTH +: WIDTH]
stall  in  1  decode cannot consume the head entry this cycle
squash  in  1  flush the whole queue (branch/jump redirect)
out_valid  out  1  head entry is valid
out_inst  out  WIDTH  head instruction, or NOP
out_slots  out  SLOTS*WIDTH  head payload words, or 0
count  out  $clog2(DEPTH+1)  number of occupied entries

Behaviour:
- Storage: DEPTH x (WIDTH*(SLOTS+1)) registers; write pointer wp, read pointer rp, each $clog2(DEPTH) bits, wrapping modulo DEPTH; separate occupancy counter drives count.
- Reset (priority 1): wp=rp=0, count=0. Outputs in the following cycle: out_valid=0, out_inst=NOP, out_slots=0, in_ready=1. Storage contents are not cleared.
- Outputs combinational from state:
  - out_valid = (count!=0).
  - out_inst/out_slots = head entry when out_valid, otherwise NOP/0.
  - in_ready = (count!=DEPTH).
- push = in_valid & in_ready & ~squash. pop = out_valid & ~stall & ~squash.
- Squash (priority 2):
  - Next edge: wp=rp=0, count=0.
  - Any same-cycle push is discarded; any same-cycle pop is discarded.
  - From the next cycle, decode sees NOP/0 with out_valid=0 until a new push lands.
  - Squash during stall behaves identically.
- Normal cycle:
  - push: write entry at wp, wp+1.
  - pop: rp+1.
  - count += push - pop. Simultaneous push and pop leaves count unchanged.
- Latency: an entry pushed into an empty queue appears on out_* in the following cycle (no fall-through). Throughput is one entry per cycle when neither stall nor full.
- Full: in_ready=0, so push is blocked even if pop occurs the same cycle. Fetch must hold in_* while in_ready=0.
- Empty with stall=0: no pop; NOP is presented, so decode sees a bubble.
- Stall with entries: head is held unchanged; pushes continue until full.
- Pointer wrap: wp/rp roll from DEPTH-1 to 0 with no discontinuity. FIFO order is preserved across the wrap.
- count never exceeds DEPTH and never underflows. Assertions: no push when full, no pop when empty.

Test Plan:
- Reset: assert reset 2 cycles with in_valid=1 -> count=0, out_valid=0, out_inst=32'h00000015, out_slots=0, in_ready=1.
- Fill under stall: stall=1, push A0..A3 (in_inst=0x100+i, slot0=0x200+i, slot1=0x300+i) -> count=4, in_ready=0, head stays 0x100; pushing A4 has no effect. Release stall -> out_inst 0x100,0x101,0x102,0x103 on consecutive cycles, then NOP with out_valid=0.
- Steady stream: continuous push with stall=0 for 10 entries -> count stays 1 after the first cycle; outputs appear in order with 1-cycle latency; pointers wrap twice with no loss or duplication.
- Squash: 3 entries queued, squash=1 together with in_valid=1 (0xDEAD) -> next cycle count=0, out_inst=NOP, out_valid=0; 0xDEAD never appears. Next push 0xBEEF appears one cycle later.
- Reset mid-operation: count=3, stall=0, reset=1 for 1 cycle -> next cycle count=0, out_inst=NOP; a subsequent push 0x55 is the next output, with no stale entries.
- Parameter sweep: WIDTH=16, SLOTS=3, DEPTH=8 -> fill to 8 and in_ready=0; each of the 3 slots round-trips its distinct value; count width is 4 bits.
